// File: rtl/scoreboard_pkg.sv
// scoreboard_pkg: shared button FSM states and timing defaults for the 1 kHz scoreboard front end
package scoreboard_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS_DB,
        PRESSED,
        HELD,
        RELEASE_DB
    } btn_state_t;

    localparam int DEBOUNCE_MS   = 20;
    localparam int LONG_PRESS_MS = 1000;

endpackage

// File: rtl/sync_ff.sv
// sync_ff: multi-flop synchroniser for one asynchronous input with a chosen reset level
module sync_ff #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            chain <= {STAGES{RST_VAL}};
        else
            chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: synchronise, debounce and classify one pushbutton into level and single-cycle press/long/release events
module button_conditioner
    import scoreboard_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_MS,
    parameter int LONG_CYCLES     = LONG_PRESS_MS,
    parameter bit ACTIVE_HIGH     = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic btn_level_o,
    output logic press_pulse_o,
    output logic long_pulse_o,
    output logic release_pulse_o
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CYCLES);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("button_conditioner: SYNC_STAGES must be at least 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
        $error("button_conditioner: DEBOUNCE_CYCLES must be at least 1");
    end
    if (LONG_CYCLES < 1) begin : g_bad_long
        $error("button_conditioner: LONG_CYCLES must be at least 1");
    end

    btn_state_t    state;
    logic          btn_raw;
    logic          btn_s;
    logic          long_done;
    logic [DW-1:0] deb_cnt;
    logic [DW-1:0] deb_inc;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_inc;

    // Synchroniser resets to the idle pad level so polarity inversion yields "not pressed"
    sync_ff #(
        .STAGES (SYNC_STAGES),
        .RST_VAL(~ACTIVE_HIGH)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (btn_i),
        .q    (btn_raw)
    );

    assign btn_s    = ACTIVE_HIGH ? btn_raw : ~btn_raw;
    assign deb_inc  = (deb_cnt == DEB_MAX) ? deb_cnt : deb_cnt + DW'(1);
    assign hold_inc = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + HW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            deb_cnt         <= '0;
            hold_cnt        <= '0;
            long_done       <= 1'b0;
            btn_level_o     <= 1'b0;
            press_pulse_o   <= 1'b0;
            long_pulse_o    <= 1'b0;
            release_pulse_o <= 1'b0;
        end else begin
            press_pulse_o   <= 1'b0;
            long_pulse_o    <= 1'b0;
            release_pulse_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (btn_s) begin
                        state   <= PRESS_DB;
                        deb_cnt <= DW'(1);
                    end
                end
                PRESS_DB: begin
                    if (!btn_s) begin
                        state   <= IDLE;
                        deb_cnt <= '0;
                    end else if (deb_cnt == DEB_MAX) begin
                        state         <= PRESSED;
                        press_pulse_o <= 1'b1;
                        btn_level_o   <= 1'b1;
                        hold_cnt      <= '0;
                        long_done     <= 1'b0;
                    end else begin
                        deb_cnt <= deb_inc;
                    end
                end
                PRESSED: begin
                    hold_cnt <= hold_inc;
                    if (!btn_s) begin
                        state   <= RELEASE_DB;
                        deb_cnt <= DW'(1);
                    end else if (hold_inc == HOLD_MAX) begin
                        state        <= HELD;
                        long_pulse_o <= 1'b1;
                        long_done    <= 1'b1;
                    end
                end
                HELD: begin
                    hold_cnt <= hold_inc;
                    if (!btn_s) begin
                        state   <= RELEASE_DB;
                        deb_cnt <= DW'(1);
                    end
                end
                RELEASE_DB: begin
                    // Hold timing keeps running so a release bounce cannot postpone the long press
                    hold_cnt <= hold_inc;
                    if (btn_s) begin
                        state <= long_done ? HELD : PRESSED;
                    end else if (deb_cnt == DEB_MAX) begin
                        state           <= IDLE;
                        release_pulse_o <= 1'b1;
                        btn_level_o     <= 1'b0;
                        deb_cnt         <= '0;
                        hold_cnt        <= '0;
                    end else begin
                        deb_cnt <= deb_inc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
